// File: rtl/calc2_req_adapter_if.sv
// Valid/ready request/response bus plus the calc2 port wiring for one calc2_req_adapter.
// The adapter takes the slave view; the requester/calc2 side takes the master view.
interface calc2_req_adapter_if;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_cmd;
    logic [31:0] req_op1;
    logic [31:0] req_op2;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_code;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_tag;

    logic [3:0]  cmd_out;
    logic [31:0] data_out;
    logic [1:0]  tag_out;

    logic [1:0]  resp_in;
    logic [31:0] data_in;
    logic [1:0]  tag_in;

    logic [3:0]  outstanding;
    logic        err_unexp;

    modport slave (
        input  req_valid, req_cmd, req_op1, req_op2, rsp_ready, resp_in, data_in, tag_in,
        output req_ready, rsp_valid, rsp_code, rsp_data, rsp_tag,
               cmd_out, data_out, tag_out, outstanding, err_unexp
    );

    modport master (
        output req_valid, req_cmd, req_op1, req_op2, rsp_ready, resp_in, data_in, tag_in,
        input  req_ready, rsp_valid, rsp_code, rsp_data, rsp_tag,
               cmd_out, data_out, tag_out, outstanding, err_unexp
    );
endinterface

// File: rtl/calc2_req_adapter.sv
// Per-port calc2 front end: tag allocation, two-cycle request issue, response
// collection by tag with per-tag timeout, and a 4-entry in-order response FIFO.
module calc2_req_adapter #(
    parameter int unsigned TIMEOUT = 64
) (
    input logic               c_clk,
    input logic               reset,
    calc2_req_adapter_if.slave bus
);

    // state | meaning
    // IDLE  | calc-side outputs 0, ready for a request
    // SEND1 | cmd/op1/tag on the calc2 port
    // SEND2 | op2 on the calc2 port, may accept the next request
    typedef enum logic [1:0] {IDLE, SEND1, SEND2} state_e;

    localparam int AW = $clog2(TIMEOUT + 1);
    localparam logic [AW-1:0] AGE_MAX = AW'(TIMEOUT);

    typedef struct packed {
        logic [1:0]  code;
        logic [31:0] data;
        logic [1:0]  tag;
    } entry_t;

    state_e      state_q;
    logic [3:0]  cmd_q;
    logic [31:0] data_q;
    logic [1:0]  tag_q;
    logic [31:0] op2_q;

    logic [3:0]    outst_q, outst_d;
    logic [AW-1:0] age_q [4];
    logic [AW-1:0] age_d [4];
    logic          err_q, err_d;

    entry_t     fifo_q [4];
    logic [1:0] wr_q, rd_q;
    logic [2:0] cnt_q;

    logic       req_ready;
    logic       accept;
    logic [1:0] alloc_tag;
    logic       rsp_hit, rsp_unexp;
    logic [3:0] expired;
    logic       to_valid;
    logic [1:0] to_tag;
    logic       push, pop;
    entry_t     push_entry;
    entry_t     head;
    logic       rsp_valid;

    assign req_ready = ~reset & ((state_q == IDLE) | (state_q == SEND2)) & (outst_q != 4'hF);
    assign accept    = bus.req_valid & req_ready;

    always_comb begin
        alloc_tag = '0;
        for (int i = 3; i >= 0; i--) begin
            if (!outst_q[i]) alloc_tag = 2'(i);
        end
    end

    assign rsp_hit   = (bus.resp_in != 2'b00) &  outst_q[bus.tag_in];
    assign rsp_unexp = (bus.resp_in != 2'b00) & ~outst_q[bus.tag_in];

    always_comb begin
        expired = '0;
        for (int i = 0; i < 4; i++) expired[i] = outst_q[i] & (age_q[i] == AGE_MAX);
    end

    always_comb begin
        to_tag = '0;
        for (int i = 3; i >= 0; i--) begin
            if (expired[i]) to_tag = 2'(i);
        end
    end

    // A real response always takes the single push slot; a pending timeout waits.
    assign to_valid = ~rsp_hit & (expired != 4'h0);
    assign push     = rsp_hit | to_valid;

    always_comb begin
        if (rsp_hit) push_entry = '{code: bus.resp_in, data: bus.data_in, tag: bus.tag_in};
        else         push_entry = '{code: 2'b11, data: 32'h0, tag: to_tag};
    end

    always_comb begin
        outst_d = outst_q;
        if (rsp_hit)       outst_d[bus.tag_in] = 1'b0;
        else if (to_valid) outst_d[to_tag]     = 1'b0;
        if (accept)        outst_d[alloc_tag]  = 1'b1;
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            age_d[i] = age_q[i];
            if (accept && (alloc_tag == 2'(i)))            age_d[i] = '0;
            else if (outst_q[i] && (age_q[i] != AGE_MAX)) age_d[i] = age_q[i] + 1'b1;
        end
    end

    assign err_d = err_q | rsp_unexp;

    assign rsp_valid = (cnt_q != 3'd0);
    assign pop       = rsp_valid & bus.rsp_ready;
    assign head      = fifo_q[rd_q];

    always_ff @(posedge c_clk) begin
        if (reset) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            data_q  <= '0;
            tag_q   <= '0;
            op2_q   <= '0;
        end else begin
            case (state_q)
                SEND1: begin
                    state_q <= SEND2;
                    cmd_q   <= '0;
                    data_q  <= op2_q;
                    tag_q   <= '0;
                end
                default: begin
                    if (accept) begin
                        state_q <= SEND1;
                        cmd_q   <= bus.req_cmd;
                        data_q  <= bus.req_op1;
                        tag_q   <= alloc_tag;
                        op2_q   <= bus.req_op2;
                    end else begin
                        state_q <= IDLE;
                        cmd_q   <= '0;
                        data_q  <= '0;
                        tag_q   <= '0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge c_clk) begin
        if (reset) begin
            outst_q <= '0;
            err_q   <= 1'b0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < 4; i++) age_q[i] <= '0;
        end else begin
            outst_q <= outst_d;
            err_q   <= err_d;
            for (int i = 0; i < 4; i++) age_q[i] <= age_d[i];
            if (push) begin
                fifo_q[wr_q] <= push_entry;
                wr_q         <= wr_q + 2'd1;
            end
            if (pop) rd_q <= rd_q + 2'd1;
            cnt_q <= cnt_q + 3'(push) - 3'(pop);
        end
    end

    assign bus.req_ready   = req_ready;
    assign bus.rsp_valid   = rsp_valid;
    assign bus.rsp_code    = rsp_valid ? head.code : 2'b00;
    assign bus.rsp_data    = rsp_valid ? head.data : 32'h0;
    assign bus.rsp_tag     = rsp_valid ? head.tag  : 2'b00;
    assign bus.cmd_out     = cmd_q;
    assign bus.data_out    = data_q;
    assign bus.tag_out     = tag_q;
    assign bus.outstanding = outst_q;
    assign bus.err_unexp   = err_q;

endmodule

// File: tb/tb_calc2_req_adapter.sv
// Directed bench for calc2_req_adapter with TIMEOUT=16; expected values are hand-computed.
module tb_calc2_req_adapter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    calc2_req_adapter_if bus();

    calc2_req_adapter #(.TIMEOUT(16)) dut (
        .c_clk (clk),
        .reset (rst),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        check_eq("rst_req_ready", 64'(bus.req_ready), 64'd0);
        check_eq("rst_cmd_out", 64'(bus.cmd_out), 64'd0);
        check_eq("rst_outstanding", 64'(bus.outstanding), 64'd0);
        check_eq("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        rst = 1'b0;
        #1;
    endtask

    // Accept at the next edge, then step through SEND1; returns positioned in SEND2.
    task automatic issue(input logic [3:0] cmd, input logic [31:0] op1, input logic [31:0] op2);
        bus.req_valid = 1'b1;
        bus.req_cmd   = cmd;
        bus.req_op1   = op1;
        bus.req_op2   = op2;
        tick();
        bus.req_valid = 1'b0;
        tick();
    endtask

    task automatic respond(input logic [1:0] code, input logic [1:0] tag, input logic [31:0] data);
        bus.resp_in = code;
        bus.tag_in  = tag;
        bus.data_in = data;
        tick();
        bus.resp_in = 2'b00;
    endtask

    logic [1:0] exp_order [4];

    initial begin
        bus.req_valid = 1'b0;
        bus.req_cmd   = '0;
        bus.req_op1   = '0;
        bus.req_op2   = '0;
        bus.rsp_ready = 1'b0;
        bus.resp_in   = '0;
        bus.data_in   = '0;
        bus.tag_in    = '0;

        // 1: single add request and response
        apply_reset();
        check_eq("t1_ready_after_rst", 64'(bus.req_ready), 64'd1);
        check_eq("t1_err_after_rst", 64'(bus.err_unexp), 64'd0);
        bus.req_valid = 1'b1;
        bus.req_cmd   = 4'd1;
        bus.req_op1   = 32'h30;
        bus.req_op2   = 32'h20;
        tick();
        bus.req_valid = 1'b0;
        check_eq("t1_send1_cmd", 64'(bus.cmd_out), 64'd1);
        check_eq("t1_send1_data", 64'(bus.data_out), 64'h30);
        check_eq("t1_send1_tag", 64'(bus.tag_out), 64'd0);
        check_eq("t1_outst", 64'(bus.outstanding), 64'h1);
        check_eq("t1_send1_ready", 64'(bus.req_ready), 64'd0);
        tick();
        check_eq("t1_send2_cmd", 64'(bus.cmd_out), 64'd0);
        check_eq("t1_send2_data", 64'(bus.data_out), 64'h20);
        check_eq("t1_send2_ready", 64'(bus.req_ready), 64'd1);
        respond(2'b01, 2'd0, 32'h50);
        check_eq("t1_idle_data", 64'(bus.data_out), 64'd0);
        check_eq("t1_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        check_eq("t1_rsp_code", 64'(bus.rsp_code), 64'd1);
        check_eq("t1_rsp_data", 64'(bus.rsp_data), 64'h50);
        check_eq("t1_rsp_tag", 64'(bus.rsp_tag), 64'd0);
        check_eq("t1_outst_clear", 64'(bus.outstanding), 64'd0);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        check_eq("t1_rsp_popped", 64'(bus.rsp_valid), 64'd0);

        // 2: five back-to-back requests, fifth waits for a free tag
        apply_reset();
        bus.req_valid = 1'b1;
        bus.req_cmd   = 4'd2;
        bus.req_op2   = 32'h55;
        for (int i = 0; i < 4; i++) begin
            bus.req_op1 = 32'h100 + 32'(i);
            tick();
            check_eq("t2_tag", 64'(bus.tag_out), 64'(i));
            check_eq("t2_op1", 64'(bus.data_out), 64'h100 + 64'(i));
            check_eq("t2_outst", 64'(bus.outstanding), (64'd1 << (i + 1)) - 64'd1);
            tick();
            check_eq("t2_op2", 64'(bus.data_out), 64'h55);
        end
        check_eq("t2_full_ready_send2", 64'(bus.req_ready), 64'd0);
        tick();
        check_eq("t2_full_ready_idle", 64'(bus.req_ready), 64'd0);
        check_eq("t2_idle_cmd", 64'(bus.cmd_out), 64'd0);
        respond(2'b01, 2'd2, 32'h22);
        check_eq("t2_ready_after_rsp", 64'(bus.req_ready), 64'd1);
        check_eq("t2_outst_after_rsp", 64'(bus.outstanding), 64'hB);
        check_eq("t2_not_yet_issued", 64'(bus.cmd_out), 64'd0);
        tick();
        bus.req_valid = 1'b0;
        check_eq("t2_fifth_tag", 64'(bus.tag_out), 64'd2);
        check_eq("t2_fifth_cmd", 64'(bus.cmd_out), 64'd2);
        check_eq("t2_outst_full", 64'(bus.outstanding), 64'hF);

        // 3: out-of-order responses fill the FIFO, drained in arrival order
        apply_reset();
        for (int i = 0; i < 4; i++) issue(4'd1, 32'(i), 32'h1);
        exp_order[0] = 2'd3;
        exp_order[1] = 2'd1;
        exp_order[2] = 2'd0;
        exp_order[3] = 2'd2;
        for (int k = 0; k < 4; k++) respond(2'b01, exp_order[k], 32'hA0 + 32'(exp_order[k]));
        check_eq("t3_outst_zero", 64'(bus.outstanding), 64'd0);
        check_eq("t3_head_tag", 64'(bus.rsp_tag), 64'd3);
        tick();
        check_eq("t3_hold_tag", 64'(bus.rsp_tag), 64'd3);
        check_eq("t3_hold_data", 64'(bus.rsp_data), 64'hA3);
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check_eq("t3_drain_valid", 64'(bus.rsp_valid), 64'd1);
            check_eq("t3_drain_tag", 64'(bus.rsp_tag), 64'(exp_order[k]));
            check_eq("t3_drain_data", 64'(bus.rsp_data), 64'hA0 + 64'(exp_order[k]));
            tick();
        end
        bus.rsp_ready = 1'b0;
        check_eq("t3_empty", 64'(bus.rsp_valid), 64'd0);

        // 4: tag0 times out, late response is unexpected
        apply_reset();
        issue(4'd6, 32'h8, 32'h1);
        ticks(15);
        check_eq("t4_before_to_valid", 64'(bus.rsp_valid), 64'd0);
        check_eq("t4_before_to_outst", 64'(bus.outstanding), 64'h1);
        tick();
        check_eq("t4_to_valid", 64'(bus.rsp_valid), 64'd1);
        check_eq("t4_to_code", 64'(bus.rsp_code), 64'd3);
        check_eq("t4_to_data", 64'(bus.rsp_data), 64'd0);
        check_eq("t4_to_tag", 64'(bus.rsp_tag), 64'd0);
        check_eq("t4_to_outst", 64'(bus.outstanding), 64'd0);
        check_eq("t4_err_before", 64'(bus.err_unexp), 64'd0);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        respond(2'b01, 2'd0, 32'h99);
        check_eq("t4_err_set", 64'(bus.err_unexp), 64'd1);
        check_eq("t4_late_dropped", 64'(bus.rsp_valid), 64'd0);
        tick();
        check_eq("t4_err_sticky", 64'(bus.err_unexp), 64'd1);

        // 5: tag1 response collides with tag0 timeout
        apply_reset();
        issue(4'd1, 32'h1, 32'h2);
        issue(4'd1, 32'h3, 32'h4);
        ticks(13);
        check_eq("t5_pre_outst", 64'(bus.outstanding), 64'h3);
        respond(2'b01, 2'd1, 32'h77);
        check_eq("t5_first_tag", 64'(bus.rsp_tag), 64'd1);
        check_eq("t5_first_code", 64'(bus.rsp_code), 64'd1);
        check_eq("t5_tag0_waits", 64'(bus.outstanding), 64'h1);
        tick();
        check_eq("t5_outst_clear", 64'(bus.outstanding), 64'd0);
        check_eq("t5_head_still_tag1", 64'(bus.rsp_tag), 64'd1);
        bus.rsp_ready = 1'b1;
        tick();
        check_eq("t5_second_tag", 64'(bus.rsp_tag), 64'd0);
        check_eq("t5_second_code", 64'(bus.rsp_code), 64'd3);
        check_eq("t5_second_data", 64'(bus.rsp_data), 64'd0);
        tick();
        bus.rsp_ready = 1'b0;
        check_eq("t5_empty", 64'(bus.rsp_valid), 64'd0);
        check_eq("t5_no_err", 64'(bus.err_unexp), 64'd0);

        // 6: reset during SEND1
        apply_reset();
        bus.req_valid = 1'b1;
        bus.req_cmd   = 4'd5;
        bus.req_op1   = 32'hDEAD;
        bus.req_op2   = 32'hBEEF;
        tick();
        bus.req_valid = 1'b0;
        check_eq("t6_in_send1", 64'(bus.data_out), 64'hDEAD);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check_eq("t6_cmd0", 64'(bus.cmd_out), 64'd0);
        check_eq("t6_data0", 64'(bus.data_out), 64'd0);
        check_eq("t6_tag0", 64'(bus.tag_out), 64'd0);
        check_eq("t6_outst0", 64'(bus.outstanding), 64'd0);
        check_eq("t6_rsp_valid0", 64'(bus.rsp_valid), 64'd0);
        bus.req_valid = 1'b1;
        bus.req_op1   = 32'h1234;
        tick();
        bus.req_valid = 1'b0;
        check_eq("t6_new_tag", 64'(bus.tag_out), 64'd0);
        check_eq("t6_new_op1", 64'(bus.data_out), 64'h1234);
        check_eq("t6_new_outst", 64'(bus.outstanding), 64'h1);
        respond(2'b01, 2'd1, 32'h5);
        check_eq("t6_unexp", 64'(bus.err_unexp), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
